logic_unit_arbiter: RTL and testbench

Shares one 32-bit bitwise logic datapath (AND/OR/NOR/XOR, built from the team's structural 32-bit bitwise units) between two requesters. Arbitrates requests round-robin, launches the selected operation, and holds the result in a one-entry output register with valid/ready backpressure. Sits between the two issuing blocks (e.g. ALU issue and address-compute path) and the shared logic unit. Keeps a per-requester completion count for debug.

---
 rtl/logic_unit_arbiter.sv | 139 +++++++++++++
 tb/tb_logic_unit_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 32-bit bitwise
// logic unit (AND/OR/NOR/XOR). The result lands in a one-entry output
// register with valid/ready handshaking. Per-requester completion counters
// are kept for debug.
module logic_unit_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [1:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [1:0]  req1_op,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_id,
   output logic [15:0] cnt0,
   output logic [15:0] cnt1
);

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e      state_q, state_d;
   logic [31:0] res_data_q, res_data_d;
   logic        res_id_q, res_id_d;
   logic        last_grant_q, last_grant_d;
   logic [15:0] cnt0_q, cnt0_d;
   logic [15:0] cnt1_q, cnt1_d;

   logic        can_accept;
   logic        grant_valid;
   logic        grant_id;
   logic        accept;
   logic        handshake;
   logic [31:0] sel_a, sel_b;
   logic [1:0]  sel_op;
   logic [31:0] op_result;

   // Bitwise logic unit: 00 AND, 01 OR, 10 NOR, 11 XOR.
   function automatic logic [31:0] logic_fn(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [31:0] r;
      r = '0;
      unique case (op)
         2'b00: r = a & b;
         2'b01: r = a | b;
         2'b10: r = ~(a | b);
         2'b11: r = a ^ b;
         default: r = '0;
      endcase
      return r;
   endfunction

   // Round-robin grant: on a tie the requester not served last wins.
   always_comb begin
      grant_valid = req0_valid | req1_valid;
      grant_id    = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant_q;
      end else if (req1_valid) begin
         grant_id = 1'b1;
      end
   end

   // Handshake qualifiers and readies; a drain frees the register in the same cycle.
   always_comb begin
      can_accept = (state_q == StEmpty) || res_ready;
      accept     = can_accept && grant_valid;
      handshake  = (state_q == StFull) && res_ready;
      req0_ready = can_accept && grant_valid && !grant_id;
      req1_ready = can_accept && grant_valid && grant_id;
   end

   // Operand mux and shared logic unit.
   always_comb begin
      sel_a     = grant_id ? req1_a  : req0_a;
      sel_b     = grant_id ? req1_b  : req0_b;
      sel_op    = grant_id ? req1_op : req0_op;
      op_result = logic_fn(sel_op, sel_a, sel_b);
   end

   // Next-state for the output register, arbitration history and counters.
   always_comb begin
      state_d      = state_q;
      res_data_d   = res_data_q;
      res_id_d     = res_id_q;
      last_grant_d = last_grant_q;
      cnt0_d       = cnt0_q;
      cnt1_d       = cnt1_q;

      if (accept) begin
         state_d      = StFull;
         res_data_d   = op_result;
         res_id_d     = grant_id;
         last_grant_d = grant_id;
      end else if (handshake) begin
         state_d = StEmpty;
      end

      if (handshake) begin
         if (res_id_q) cnt1_d = cnt1_q + 16'd1;
         else          cnt0_d = cnt0_q + 16'd1;
      end
   end

   // State registers; last_grant resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StEmpty;
         res_data_q   <= '0;
         res_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
      end else begin
         state_q      <= state_d;
         res_data_q   <= res_data_d;
         res_id_q     <= res_id_d;
         last_grant_q <= last_grant_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
      end
   end

   // Registered outputs.
   always_comb begin
      res_valid = (state_q == StFull);
      res_data  = res_data_q;
      res_id    = res_id_q;
      cnt0      = cnt0_q;
      cnt1      = cnt1_q;
   end

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed, table-driven bench for logic_unit_arbiter.
module tb_logic_unit_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_a, req0_b;
   logic [1:0]  req0_op;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_a, req1_b;
   logic [1:0]  req1_op;
   logic        res_valid, res_ready;
   logic [31:0] res_data;
   logic        res_id;
   logic [15:0] cnt0, cnt1;

   int errors = 0;
   int checks = 0;

   logic_unit_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_id     (res_id),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [1:0] OpAnd = 2'b00, OpOr = 2'b01, OpNor = 2'b10, OpXor = 2'b11;

   typedef struct packed {
      logic        v0;
      logic [1:0]  op0;
      logic [31:0] a0;
      logic [31:0] b0;
      logic        v1;
      logic [1:0]  op1;
      logic [31:0] a1;
      logic [31:0] b1;
      logic        exp_rdy0;
      logic        exp_rdy1;
      logic        exp_id;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      req0_valid = 0; req0_a = '0; req0_b = '0; req0_op = OpAnd;
      req1_valid = 0; req1_a = '0; req1_b = '0; req1_op = OpAnd;
   endtask

   task automatic apply(input vec_t v);
      req0_valid = v.v0; req0_op = v.op0; req0_a = v.a0; req0_b = v.b0;
      req1_valid = v.v1; req1_op = v.op1; req1_a = v.a1; req1_b = v.b1;
   endtask

   int exp_c0, exp_c1;
   int acc, hs;
   logic [31:0] held;

   initial begin
      // v0 op0 a0 b0 | v1 op1 a1 b1 | rdy0 rdy1 id data
      vecs[0] = '{1, OpNor, 32'h0F0F0000, 32'h00FF00FF, 0, OpAnd, 32'h0, 32'h0,
                  1, 0, 0, 32'hF000FF00};
      vecs[1] = '{0, OpAnd, 32'h0, 32'h0, 1, OpAnd, 32'hFF00FF00, 32'h0FF00FF0,
                  0, 1, 1, 32'h0F000F00};
      vecs[2] = '{1, OpOr, 32'h12340000, 32'h00005678, 0, OpAnd, 32'h0, 32'h0,
                  1, 0, 0, 32'h12345678};
      vecs[3] = '{0, OpAnd, 32'h0, 32'h0, 1, OpXor, 32'hFFFF0000, 32'h0F0F0F0F,
                  0, 1, 1, 32'hF0F00F0F};
      vecs[4] = '{1, OpAnd, 32'hFFFF0000, 32'h12345678, 1, OpXor, 32'hAAAAAAAA, 32'h55555555,
                  1, 0, 0, 32'h12340000};
      vecs[5] = '{1, OpAnd, 32'hFFFF0000, 32'h12345678, 1, OpXor, 32'hAAAAAAAA, 32'h55555555,
                  0, 1, 1, 32'hFFFFFFFF};
      vecs[6] = '{1, OpAnd, 32'hFFFF0000, 32'h12345678, 1, OpXor, 32'hAAAAAAAA, 32'h55555555,
                  1, 0, 0, 32'h12340000};
      vecs[7] = '{1, OpAnd, 32'hFFFF0000, 32'h12345678, 1, OpXor, 32'hAAAAAAAA, 32'h55555555,
                  0, 1, 1, 32'hFFFFFFFF};
      vecs[8] = '{1, OpAnd, 32'hFFFF0000, 32'h12345678, 0, OpAnd, 32'h0, 32'h0,
                  1, 0, 0, 32'h12340000};
      vecs[9] = '{0, OpAnd, 32'h0, 32'h0, 1, OpNor, 32'h0, 32'h0,
                  0, 1, 1, 32'hFFFFFFFF};

      idle_inputs();
      res_ready = 1'b0;
      rst_n     = 1'b0;
      #1;
      chk("reset res_valid", {31'b0, res_valid}, 32'h0);
      chk("reset res_data", res_data, 32'h0);
      chk("reset res_id", {31'b0, res_id}, 32'h0);
      chk("reset cnt0", {16'b0, cnt0}, 32'h0);
      chk("reset cnt1", {16'b0, cnt1}, 32'h0);
      chk("reset req0_ready", {31'b0, req0_ready}, 32'h0);
      chk("reset req1_ready", {31'b0, req1_ready}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Table: one vector per cycle, result checked on the following cycle.
      res_ready = 1'b1;
      exp_c0 = 0; exp_c1 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk($sformatf("vec%0d res_valid", i - 1), {31'b0, res_valid}, 32'h1);
            chk($sformatf("vec%0d res_id", i - 1), {31'b0, res_id}, {31'b0, vecs[i-1].exp_id});
            chk($sformatf("vec%0d res_data", i - 1), res_data, vecs[i-1].exp_data);
         end
         apply(vecs[i]);
         #1;
         chk($sformatf("vec%0d req0_ready", i), {31'b0, req0_ready}, {31'b0, vecs[i].exp_rdy0});
         chk($sformatf("vec%0d req1_ready", i), {31'b0, req1_ready}, {31'b0, vecs[i].exp_rdy1});
         if (i > 0) begin
            if (vecs[i-1].exp_id) exp_c1++;
            else                  exp_c0++;
         end
      end
      @(negedge clk);
      chk("vec9 res_valid", {31'b0, res_valid}, 32'h1);
      chk("vec9 res_id", {31'b0, res_id}, {31'b0, vecs[9].exp_id});
      chk("vec9 res_data", res_data, vecs[9].exp_data);
      exp_c1++;
      idle_inputs();

      // Idle drain: last result consumed, nothing new.
      @(negedge clk);
      chk("idle res_valid", {31'b0, res_valid}, 32'h0);
      chk("idle res_data held", res_data, 32'hFFFFFFFF);
      chk("idle cnt0", {16'b0, cnt0}, exp_c0[31:0]);
      chk("idle cnt1", {16'b0, cnt1}, exp_c1[31:0]);
      chk("idle cnt0 const", {16'b0, cnt0}, 32'd5);

      // Backpressure: hold a req0 result with req1 OR waiting behind it.
      res_ready  = 1'b0;
      req0_valid = 1; req0_op = OpAnd; req0_a = 32'hF0F0F0F0; req0_b = 32'hFF00FF00;
      #1;
      chk("bp req0_ready into empty", {31'b0, req0_ready}, 32'h1);
      @(negedge clk);
      idle_inputs();
      req1_valid = 1; req1_op = OpOr; req1_a = 32'h0000FFFF; req1_b = 32'h00FF0000;
      chk("bp held valid", {31'b0, res_valid}, 32'h1);
      chk("bp held data", res_data, 32'hF000F000);
      held = res_data;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("bp cyc%0d req0_ready", c), {31'b0, req0_ready}, 32'h0);
         chk($sformatf("bp cyc%0d req1_ready", c), {31'b0, req1_ready}, 32'h0);
         chk($sformatf("bp cyc%0d data", c), res_data, held);
         chk($sformatf("bp cyc%0d id", c), {31'b0, res_id}, 32'h0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      #1;
      chk("bp drain+accept req1_ready", {31'b0, req1_ready}, 32'h1);
      @(negedge clk);
      req1_valid = 1'b0;
      chk("bp new valid", {31'b0, res_valid}, 32'h1);
      chk("bp new data", res_data, 32'h00FFFFFF);
      chk("bp new id", {31'b0, res_id}, 32'h1);
      chk("bp cnt0", {16'b0, cnt0}, 32'd6);
      @(negedge clk);
      chk("bp drained", {31'b0, res_valid}, 32'h0);
      chk("bp cnt1", {16'b0, cnt1}, 32'd6);

      // Asynchronous reset while FULL with 0xDEADBEEF.
      res_ready  = 1'b0;
      req0_valid = 1; req0_op = OpXor; req0_a = 32'hDEADBEEF; req0_b = 32'h0;
      @(negedge clk);
      idle_inputs();
      chk("pre-reset data", res_data, 32'hDEADBEEF);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst res_valid", {31'b0, res_valid}, 32'h0);
      chk("async rst res_data", res_data, 32'h0);
      chk("async rst cnt0", {16'b0, cnt0}, 32'h0);
      chk("async rst cnt1", {16'b0, cnt1}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // First tie after reset goes to requester 0.
      res_ready  = 1'b1;
      req0_valid = 1; req0_op = OpAnd; req0_a = 32'hFFFF0000; req0_b = 32'h12345678;
      req1_valid = 1; req1_op = OpXor; req1_a = 32'hAAAAAAAA; req1_b = 32'h55555555;
      #1;
      chk("post-reset tie rdy0", {31'b0, req0_ready}, 32'h1);
      chk("post-reset tie rdy1", {31'b0, req1_ready}, 32'h0);
      @(negedge clk);
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Counter wrap: 65536 req1 handshakes from reset.
      res_ready = 1'b1;
      req1_op = OpOr; req1_a = 32'h1; req1_b = 32'h2;
      acc = 0; hs = 0;
      for (int n = 0; n < 70000 && hs < 65536; n++) begin
         @(negedge clk);
         req1_valid = (acc < 65536);
         #1;
         if (req1_valid && req1_ready) acc++;
         if (res_valid && res_ready) hs++;
      end
      chk("wrap handshakes", hs, 32'd65536);
      @(negedge clk);
      req1_valid = 1'b0;
      chk("wrap cnt1", {16'b0, cnt1}, 32'h0);
      chk("wrap cnt0", {16'b0, cnt0}, 32'h0);
      chk("wrap res_valid", {31'b0, res_valid}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
